// File: rtl/tmds_encoder.sv
// -----------------------------------------------------------------------------
// tmds_encoder
//   DVI 1.0 TMDS 8b/10b encoder for a single colour channel.
//   Stage 1 applies transition minimisation to the pixel byte (producing q_m).
//   Stage 2 applies DC balancing against a running disparity, or emits a
//   control token while data enable is low. One 10-bit symbol per clock.
//
// Ports
//   i_clk    in   1   pixel clock
//   i_rstn   in   1   asynchronous active-low reset
//   i_de     in   1   data enable (1 = encode i_data, 0 = send control token)
//   i_c0     in   1   control bit 0 (HSYNC on the blue channel)
//   i_c1     in   1   control bit 1 (VSYNC on the blue channel)
//   i_data   in   8   pixel component, valid when i_de = 1
//   o_tmds   out  10  encoded symbol, bit 0 transmitted first
//   o_disp   out  5   signed running disparity after the current o_tmds symbol
// -----------------------------------------------------------------------------
module tmds_encoder #(
  parameter logic [9:0] CTL_TOK_00 = 10'b1101010100,
  parameter logic [9:0] CTL_TOK_01 = 10'b0010101011,
  parameter logic [9:0] CTL_TOK_10 = 10'b0101010100,
  parameter logic [9:0] CTL_TOK_11 = 10'b1010101011
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_de,
  input  logic              i_c0,
  input  logic              i_c1,
  input  logic [7:0]        i_data,
  output logic [9:0]        o_tmds,
  output logic signed [4:0] o_disp
);

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] sum;
    sum = '0;
    for (int i = 0; i < 8; i++) begin
      sum = sum + {3'b000, v[i]};
    end
    return sum;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage 1: transition minimisation
  // ---------------------------------------------------------------------------
  logic [3:0] n1d;
  logic       use_xnor;
  logic [8:0] qm_s1_next;

  logic [8:0] qm_s1_reg;
  logic       de_s1_reg;
  logic       c0_s1_reg;
  logic       c1_s1_reg;

  assign n1d      = popcount8(i_data);
  assign use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !i_data[0]);

  // The serial XOR/XNOR chain unrolls to a prefix parity of the data bits;
  // on the XNOR path each step adds one inversion, so odd bit positions end
  // up inverted relative to the XOR result.
  for (genvar gi = 0; gi < 8; gi++) begin : g_qm
    localparam logic ODD_POS = logic'(gi % 2);
    assign qm_s1_next[gi] = (^i_data[gi:0]) ^ (use_xnor & ODD_POS);
  end
  assign qm_s1_next[8] = ~use_xnor;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      qm_s1_reg <= '0;
      de_s1_reg <= 1'b0;
      c0_s1_reg <= 1'b0;
      c1_s1_reg <= 1'b0;
    end else begin
      qm_s1_reg <= qm_s1_next;
      de_s1_reg <= i_de;
      c0_s1_reg <= i_c0;
      c1_s1_reg <= i_c1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: DC balance
  // ---------------------------------------------------------------------------
  logic [3:0]        n1;
  logic signed [4:0] diff_s;     // n1 - n0 = 2*n1 - 8
  logic              q8;
  logic [7:0]        qm;
  logic              cnt_pos;
  logic              cnt_neg;

  logic [9:0]        tmds_reg;
  logic [9:0]        tmds_next;
  logic signed [4:0] cnt_reg;
  logic signed [4:0] cnt_next;

  assign q8      = qm_s1_reg[8];
  assign qm      = qm_s1_reg[7:0];
  assign n1      = popcount8(qm);
  assign diff_s  = signed'(5'({n1, 1'b0}) - 5'd8);
  assign cnt_pos = !cnt_reg[4] && (cnt_reg != 5'sd0);
  assign cnt_neg = cnt_reg[4];

  always_comb begin
    tmds_next = tmds_reg;
    cnt_next  = cnt_reg;
    if (!de_s1_reg) begin
      case ({c1_s1_reg, c0_s1_reg})
        2'b00:   tmds_next = CTL_TOK_00;
        2'b01:   tmds_next = CTL_TOK_01;
        2'b10:   tmds_next = CTL_TOK_10;
        default: tmds_next = CTL_TOK_11;
      endcase
      cnt_next = 5'sd0;
    end else if ((cnt_reg == 5'sd0) || (n1 == 4'd4)) begin
      // No bias to correct: bit 9 simply mirrors the opposite of q_m[8].
      tmds_next = {~q8, q8, (q8 ? qm : ~qm)};
      cnt_next  = q8 ? (cnt_reg + diff_s) : (cnt_reg - diff_s);
    end else if ((cnt_pos && (n1 > 4'd4)) || (cnt_neg && (n1 < 4'd4))) begin
      // Symbol would push disparity further the same way: invert it.
      tmds_next = {1'b1, q8, ~qm};
      cnt_next  = cnt_reg + (q8 ? 5'sd2 : 5'sd0) - diff_s;
    end else begin
      tmds_next = {1'b0, q8, qm};
      cnt_next  = cnt_reg - (q8 ? 5'sd0 : 5'sd2) + diff_s;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      tmds_reg <= CTL_TOK_00;
      cnt_reg  <= 5'sd0;
    end else begin
      tmds_reg <= tmds_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign o_tmds = tmds_reg;
  assign o_disp = cnt_reg;

endmodule

// File: tb/tb_tmds_encoder.sv
module tb_tmds_encoder;

  logic              i_clk = 1'b0;
  logic              i_rstn = 1'b1;
  logic              i_de = 1'b0;
  logic              i_c0 = 1'b0;
  logic              i_c1 = 1'b0;
  logic [7:0]        i_data = 8'h00;
  logic [9:0]        o_tmds;
  logic signed [4:0] o_disp;

  tmds_encoder dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_de   (i_de),
    .i_c0   (i_c0),
    .i_c1   (i_c1),
    .i_data (i_data),
    .o_tmds (o_tmds),
    .o_disp (o_disp)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       de;
    logic       c1;
    logic       c0;
    logic [7:0] data;
    logic [9:0] tmds;
    int         disp;
  } vec_t;

  typedef struct {
    logic       de;
    logic [7:0] data;
    logic [9:0] tmds;
    int         disp;
    string      tag;
  } exp_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_txn = 0;
  int          model_cnt = 0;
  exp_t        exp_q[$];
  logic [9:0]  tok[4];
  vec_t        tab[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference encoder working directly from the DVI rules with integers.
  task automatic model_encode(input logic de, input logic c1, input logic c0,
                              input logic [7:0] d, output logic [9:0] sym);
    int         n;
    int         ones;
    int         zeros;
    logic       xnor_path;
    logic [8:0] q;
    int         idx;
    if (!de) begin
      idx = int'({c1, c0});
      sym = tok[idx];
      model_cnt = 0;
    end else begin
      n = $countones(d);
      xnor_path = (n > 4) || (n == 4 && d[0] == 1'b0);
      q[0] = d[0];
      for (int i = 1; i < 8; i++) begin
        q[i] = xnor_path ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      end
      q[8] = !xnor_path;
      ones = $countones(q[7:0]);
      zeros = 8 - ones;
      if (model_cnt == 0 || ones == zeros) begin
        if (q[8]) begin
          sym = {2'b01, q[7:0]};
          model_cnt += ones - zeros;
        end else begin
          sym = {2'b10, ~q[7:0]};
          model_cnt += zeros - ones;
        end
      end else if ((model_cnt > 0 && ones > zeros) || (model_cnt < 0 && zeros > ones)) begin
        sym = {1'b1, q[8], ~q[7:0]};
        model_cnt += 2 * int'(q[8]) + zeros - ones;
      end else begin
        sym = {1'b0, q[8], q[7:0]};
        model_cnt += -2 * int'(!q[8]) + ones - zeros;
      end
    end
  endtask

  // Receiver-side inverse of the encoding, independent of the model above.
  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] q;
    logic [7:0] d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

  task automatic check_out(input exp_t e);
    int disp_act;
    disp_act = int'(o_disp);
    n_txn++;
    $display("txn %0d %s de=%0b tmds=%03h disp=%0d exp_tmds=%03h exp_disp=%0d",
             n_txn, e.tag, e.de, o_tmds, disp_act, e.tmds, e.disp);
    check({e.tag, "_tmds"}, 32'(o_tmds), 32'(e.tmds));
    check({e.tag, "_disp"}, 32'(disp_act), 32'(e.disp));
    check({e.tag, "_disp_range"}, 32'(disp_act >= -10 && disp_act <= 10), 32'd1);
    if (e.de) check({e.tag, "_decode"}, 32'(decode(o_tmds)), 32'(e.data));
    else      check({e.tag, "_blank_disp"}, 32'(disp_act), 32'd0);
  endtask

  // One clock of stimulus. Inputs driven after edge k are visible encoded
  // after edge k+2, so the queue holds exactly two outstanding expectations.
  task automatic tick(input logic de, input logic c1, input logic c0, input logic [7:0] d,
                      input logic use_tab, input logic [9:0] t_tmds, input int t_disp,
                      input string tag);
    exp_t       e;
    logic [9:0] sym;
    @(posedge i_clk);
    #1;
    if (exp_q.size() == 2) check_out(exp_q.pop_front());
    i_de = de;
    i_c1 = c1;
    i_c0 = c0;
    i_data = d;
    model_encode(de, c1, c0, d, sym);
    e.de = de;
    e.data = d;
    e.tag = tag;
    if (use_tab) begin
      e.tmds = t_tmds;
      e.disp = t_disp;
    end else begin
      e.tmds = sym;
      e.disp = model_cnt;
    end
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int hold);
    exp_t e;
    i_rstn = 1'b0;
    #1;
    check("rst_now_tmds", 32'(o_tmds), 32'h354);
    check("rst_now_disp", 32'(int'(o_disp)), 32'd0);
    i_de = 1'b0;
    i_c0 = 1'b0;
    i_c1 = 1'b0;
    i_data = 8'h00;
    exp_q.delete();
    model_cnt = 0;
    repeat (hold) @(posedge i_clk);
    #1;
    check("rst_hold_tmds", 32'(o_tmds), 32'h354);
    check("rst_hold_disp", 32'(int'(o_disp)), 32'd0);
    i_rstn = 1'b1;
    // The two pipeline slots drain reset contents (de=0, c=00) first.
    e.de = 1'b0;
    e.data = 8'h00;
    e.tmds = 10'h354;
    e.disp = 0;
    e.tag = "post_rst";
    exp_q.push_back(e);
    exp_q.push_back(e);
  endtask

  initial begin
    tok[0] = 10'b1101010100;
    tok[1] = 10'b0010101011;
    tok[2] = 10'b0101010100;
    tok[3] = 10'b1010101011;

    tab[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 10'h354, 0};
    tab[1]  = '{1'b0, 1'b0, 1'b1, 8'h5A, 10'h0AB, 0};
    tab[2]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 10'h154, 0};
    tab[3]  = '{1'b0, 1'b1, 1'b1, 8'hFF, 10'h2AB, 0};
    tab[4]  = '{1'b1, 1'b1, 1'b1, 8'h00, 10'h100, -8};
    tab[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 10'h3FF, 2};
    tab[6]  = '{1'b1, 1'b0, 1'b1, 8'h00, 10'h100, -6};
    tab[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 10'h354, 0};
    tab[8]  = '{1'b1, 1'b0, 1'b0, 8'hFF, 10'h200, -8};
    tab[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 10'h154, 0};
    tab[10] = '{1'b1, 1'b1, 1'b1, 8'hFF, 10'h200, -8};
    tab[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 10'h3FF, 2};

    #2;
    do_reset(3);

    for (int i = 0; i < 12; i++) begin
      tick(tab[i].de, tab[i].c1, tab[i].c0, tab[i].data, 1'b1, tab[i].tmds, tab[i].disp,
           $sformatf("tab%0d", i));
    end
    tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 10'h354, 0, "tab_end0");
    tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 10'h354, 0, "tab_end1");

    // Reduced frame: 12 active lines of 32 pixels plus blanking, 2 vblank lines.
    for (int line = 0; line < 14; line++) begin
      for (int px = 0; px < 40; px++) begin
        logic de;
        logic hs;
        logic vs;
        de = (line < 12) && (px < 32);
        hs = (px >= 34) && (px < 37);
        vs = (line >= 12);
        if (de) tick(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 1'b0, 10'h0, 0, "frame");
        else    tick(1'b0, vs, hs, 8'($urandom), 1'b0, 10'h0, 0, "frame");
      end
    end

    // Reset in the middle of an active line, then restart from cnt=0.
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0, 10'h0, 0, "pre_rst");
    #3;
    do_reset(2);
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 10'h100, -8, "resume0");
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 10'h3FF, 2, "resume1");
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 10'h100, -6, "resume2");
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0, 10'h0, 0, "resume_rnd");
    tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 10'h0, 0, "tail");
    tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 10'h0, 0, "tail");
    tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 10'h0, 0, "tail");
    tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 10'h0, 0, "tail");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
